// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int unsigned OCC_W = 2;

  // LSB position of field i in a packed bundle of w-bit fields.
  function automatic int unsigned FIELD_LSB(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/pipe_reg_bank.sv
// W-bit data register with synchronous reset to zero, clear-to-value and load enable.
module pipe_reg_bank #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_en,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Priority: reset, then clear (bubble insert), then load; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= clr_val;
    end else if (ld_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Parametrised elastic pipeline-stage register with valid/ready handshake,
// optional 1-entry skid buffer, stall, flush-to-bubble and occupancy output.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       NUM_FIELDS = 2,
  parameter int unsigned       SKID       = 1,
  parameter logic [DATA_W-1:0] FLUSH_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]             occupancy
);

  localparam int unsigned TOT_W = NUM_FIELDS * DATA_W;

  state_t            state_q, state_d;
  logic [TOT_W-1:0]  main_q, main_d, skid_q, flush_fill;
  logic              main_ld, skid_ld, push, pop;

  // Replicate the bubble encoding into every field.
  always_comb begin
    flush_fill = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      flush_fill[FIELD_LSB(i, DATA_W) +: DATA_W] = FLUSH_VAL;
    end
  end

  // Handshake decode; with a skid entry in_ready depends on state only.
  always_comb begin
    if (SKID != 0) begin
      in_ready = (state_q != ST_TWO) && !stall;
    end else begin
      in_ready = ((state_q == ST_EMPTY) || out_ready) && !stall;
    end
    out_valid = (state_q != ST_EMPTY);
    push      = in_valid && in_ready && !stall;
    pop       = out_valid && out_ready && !stall;
  end

  // Next-state and data-register load control.
  // With SKID=0 a push in ONE implies a pop, so ONE never advances to TWO.
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = in_data;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (!stall) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            state_d = ST_TWO;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_reg_bank #(.W(TOT_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (main_ld),
    .clr     (flush),
    .clr_val (flush_fill),
    .d       (main_d),
    .q       (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_reg_bank #(.W(TOT_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (skid_ld),
        .clr     (flush),
        .clr_val (flush_fill),
        .d       (in_data),
        .q       (skid_q)
      );
    end else begin : g_noskid
      logic skid_ld_unused;
      assign skid_ld_unused = skid_ld;
      assign skid_q         = '0;
    end
  endgenerate

  // Occupancy follows directly from the state.
  always_comb begin
    unique case (state_q)
      ST_ONE:  occupancy = OCC_W'(1);
      ST_TWO:  occupancy = OCC_W'(2);
      default: occupancy = '0;
    endcase
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: one SKID=1 instance (bubble 0x20) and one SKID=0
// instance share stimulus; a queue model checks both every cycle.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, out_ready;
  logic [63:0] in_data;
  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [63:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(32), .NUM_FIELDS(2), .SKID(1), .FLUSH_VAL(32'h0000_0020)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .stall(stall), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .occupancy(occ1)
  );

  pipe_stage_elastic #(.DATA_W(32), .NUM_FIELDS(2), .SKID(0), .FLUSH_VAL(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .stall(stall), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .occupancy(occ0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a bounded FIFO per instance plus the value shown when empty.
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  logic [63:0] last1, last0;
  bit          mstart = 0;

  always @(posedge clk) begin
    bit p1, o1, p0, o0;
    if (rst) begin
      q1.delete(); q0.delete();
      last1 = '0; last0 = '0;
      mstart = 1;
    end else if (mstart) begin
      if (flush) begin
        q1.delete(); q0.delete();
        last1 = {2{32'h0000_0020}};
        last0 = '0;
      end else if (!stall) begin
        p1 = in_valid && (q1.size() < 2);
        o1 = (q1.size() > 0) && out_ready;
        p0 = in_valid && ((q0.size() == 0) || out_ready);
        o0 = (q0.size() > 0) && out_ready;
        if (o1) void'(q1.pop_front());
        if (p1) q1.push_back(in_data);
        if (o0) void'(q0.pop_front());
        if (p0) q0.push_back(in_data);
      end
      if (q1.size() > 0) last1 = q1[0];
      if (q0.size() > 0) last0 = q0[0];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mstart && !rst) begin
      chk("m1.out_valid", 64'(out_valid1), 64'(q1.size() > 0));
      chk("m1.out_data",  out_data1, last1);
      chk("m1.occupancy", 64'(occ1), 64'(q1.size()));
      chk("m1.in_ready",  64'(in_ready1), 64'((q1.size() < 2) && !stall));
      chk("m0.out_valid", 64'(out_valid0), 64'(q0.size() > 0));
      chk("m0.out_data",  out_data0, last0);
      chk("m0.occupancy", 64'(occ0), 64'(q0.size()));
      chk("m0.in_ready",  64'(in_ready0), 64'(((q0.size() == 0) || out_ready) && !stall));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] dv(input int k);
    return {32'(4 * (k + 1)), 32'(32'h8C01_0004 + 4 * k)};
  endfunction

  localparam logic [63:0] A = 64'h0000_0008_8C01_0004;
  localparam logic [63:0] B = 64'h0000_000C_AC02_0008;
  localparam logic [63:0] C = 64'h0000_0010_0000_0013;
  localparam logic [63:0] E = 64'h0000_0014_1234_5678;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // 1: reset
    tick(); tick();
    rst = 1'b0;
    chk("rst.out_valid", 64'(out_valid1), 64'd0);
    chk("rst.out_data",  out_data1, 64'd0);
    chk("rst.occupancy", 64'(occ1), 64'd0);
    chk("rst.in_ready",  64'(in_ready1), 64'd1);

    // 2: streaming at full throughput, 1-cycle latency
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = dv(k);
      tick();
      chk("stream.out_data", out_data1, dv(k));
      chk("stream.occ", 64'(occ1), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain.occ", 64'(occ1), 64'd0);
    chk("drain.hold_data", out_data1, 64'h0000_0010_8C01_0010);

    // 3: fill both entries with downstream blocked
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = A; tick();
    in_data = B; tick();
    in_valid = 1'b0;
    chk("full.occ", 64'(occ1), 64'd2);
    chk("full.in_ready", 64'(in_ready1), 64'd0);
    chk("full.out_data", out_data1, A);
    chk("skid0.in_ready_blocked", 64'(in_ready0), 64'd0);

    // 4: stall holds everything even with out_ready high
    stall = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.occ", 64'(occ1), 64'd2);
      chk("stall.out_data", out_data1, A);
      chk("stall.in_ready", 64'(in_ready1), 64'd0);
    end
    stall = 1'b0;
    tick();
    chk("unstall.occ", 64'(occ1), 64'd1);
    chk("unstall.out_data", out_data1, B);
    tick();
    chk("empty.occ", 64'(occ1), 64'd0);

    // 5: flush with occupancy 2 and a live input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = A; tick();
    in_data = B; tick();
    in_data = C; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 64'(out_valid1), 64'd0);
    chk("flush.occ", 64'(occ1), 64'd0);
    chk("flush.fields", out_data1, 64'h0000_0020_0000_0020);
    tick();
    chk("flush.dropped", 64'(occ1), 64'd0);

    // flush and stall together: flush wins
    in_valid = 1'b1; in_data = A; tick();
    in_valid = 1'b0; stall = 1'b1; flush = 1'b1; tick();
    stall = 1'b0; flush = 1'b0;
    chk("flushstall.occ", 64'(occ1), 64'd0);

    // 6: SKID=0 combinational in_ready
    out_ready = 1'b1; tick();
    in_valid = 1'b1; in_data = E;
    #1;
    chk("skid0.in_ready_empty", 64'(in_ready0), 64'd1);
    tick();
    chk("skid0.occ", 64'(occ0), 64'd1);
    chk("skid0.in_ready_flow", 64'(in_ready0), 64'd1);
    out_ready = 1'b0;
    #1;
    chk("skid0.in_ready_comb", 64'(in_ready0), 64'd0);
    in_valid = 1'b0; tick();
    out_ready = 1'b1; tick(); tick();
    chk("skid0.drained", 64'(occ0), 64'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
